// File: rtl/top_racl_pkg.sv
// Shared RACL types: the error-log record and the drop-counter width.
// Consumed by racl_error_arbiter (optional counter via RACL_ERR_DROP_CNT_EN).
package top_racl_pkg;

  localparam int RACL_ROLE_W    = 4;
  localparam int CTN_UID_W      = 8;
  localparam int RACL_ADDR_W    = 32;
  localparam int RACL_ERR_CNT_W = 8;

  typedef logic [RACL_ROLE_W-1:0] racl_role_t;
  typedef logic [CTN_UID_W-1:0]   ctn_uid_t;

  typedef struct packed {
    logic                   valid;
    logic                   overflow;
    racl_role_t             racl_role;
    ctn_uid_t               ctn_uid;
    logic                   read_access;
    logic [RACL_ADDR_W-1:0] request_address;
  } racl_error_log_t;

endpackage

// File: rtl/racl_rr_arb.sv
// Round-robin arbiter: search starts at the rotating pointer, one grant per
// cycle, pointer moves past the winner. advance=0 suppresses any grant.
module racl_rr_arb #(
  parameter  int N    = 4,
  localparam int IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  logic [IdxW-1:0] ptr_reg;
  logic [IdxW-1:0] ptr_next;
  logic            found;

  always_comb begin
    int cand;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= N) cand = cand - N;
      if (!found && advance && req[IdxW'(cand)]) begin
        found                = 1'b1;
        gnt[IdxW'(cand)]     = 1'b1;
        gnt_idx              = IdxW'(cand);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (found) ptr_next = (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/racl_error_arbiter.sv
// Funnels RACL error records from NumReq checkers into one sticky log register.
// Drop counter present only when RACL_ERR_DROP_CNT_EN is defined.
module racl_error_arbiter
  import top_racl_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int SrcW   = $clog2(NumReq),
  parameter int CntW   = RACL_ERR_CNT_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  racl_error_log_t [NumReq-1:0] err_i,
  input  logic                         clear_i,
  output racl_error_log_t              log_o,
  output logic [SrcW-1:0]              log_src_o,
  output logic                         irq_o,
  output logic [CntW-1:0]              drop_cnt_o
);

  racl_error_log_t   slot_rec [NumReq];
  logic [NumReq-1:0] slot_full;
  logic [NumReq-1:0] pend_ovf;
  logic [NumReq-1:0] gnt;
  logic [SrcW-1:0]   gnt_idx;
  logic              gnt_any;
  racl_error_log_t   gnt_rec;
  racl_error_log_t   log_reg;
  logic [SrcW-1:0]   log_src_reg;

  // One-deep pending slot per requester; a granted slot can refill in the same cycle.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_slot
    racl_error_log_t slot_reg;
    logic            pend_ovf_reg;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        slot_reg     <= '0;
        pend_ovf_reg <= 1'b0;
      end else if (err_i[gi].valid && (!slot_reg.valid || gnt[gi])) begin
        slot_reg     <= err_i[gi];
        pend_ovf_reg <= 1'b0;
      end else if (err_i[gi].valid) begin
        pend_ovf_reg <= 1'b1;
      end else if (gnt[gi]) begin
        slot_reg.valid <= 1'b0;
      end
    end

    assign slot_rec[gi]  = slot_reg;
    assign slot_full[gi] = slot_reg.valid;
    assign pend_ovf[gi]  = pend_ovf_reg;
  end

  racl_rr_arb #(.N(NumReq)) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (slot_full),
    .advance (~clear_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt;

  always_comb begin
    gnt_rec          = slot_rec[gnt_idx];
    gnt_rec.valid    = 1'b1;
    gnt_rec.overflow = slot_rec[gnt_idx].overflow | pend_ovf[gnt_idx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      log_reg     <= '0;
      log_src_reg <= '0;
    end else if (gnt_any) begin
      if (!log_reg.valid) begin
        log_reg     <= gnt_rec;
        log_src_reg <= gnt_idx;
      end else begin
        log_reg.overflow <= 1'b1;
      end
    end
  end

  assign log_o     = log_reg;
  assign log_src_o = log_src_reg;
  assign irq_o     = log_reg.valid;

`ifdef RACL_ERR_DROP_CNT_EN
  localparam int SumW = CntW + 5;
  localparam logic [SumW-1:0] CntMax = {{5{1'b0}}, {CntW{1'b1}}};

  logic [CntW-1:0] drop_cnt_reg;
  logic [SumW-1:0] drop_inc;
  logic [SumW-1:0] drop_sum;

  // Slot drops and a log discard can coincide, so sum them before saturating.
  always_comb begin
    drop_inc = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (err_i[k].valid && slot_full[k] && !gnt[k]) drop_inc = drop_inc + 1'b1;
    end
    if (gnt_any && log_reg.valid) drop_inc = drop_inc + 1'b1;
    drop_sum = {5'b0, drop_cnt_reg} + drop_inc;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)      drop_cnt_reg <= '0;
    else if (drop_sum > CntMax) drop_cnt_reg <= '1;
    else                        drop_cnt_reg <= drop_sum[CntW-1:0];
  end

  assign drop_cnt_o = drop_cnt_reg;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_racl_error_arbiter.sv
// Directed bench for racl_error_arbiter; drop-count expectations follow
// RACL_ERR_DROP_CNT_EN (zero when the macro is undefined).
module tb_racl_error_arbiter;
  import top_racl_pkg::*;

  localparam int NumReq = 4;

`ifdef RACL_ERR_DROP_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic                         clk_i = 1'b0;
  logic                         rst_i;
  logic                         clear_i;
  racl_error_log_t [NumReq-1:0] err_i;
  racl_error_log_t              log_o;
  logic [1:0]                   log_src_o;
  logic                         irq_o;
  logic [7:0]                   drop_cnt_o;

  int checks = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  racl_error_arbiter #(.NumReq(NumReq)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .err_i      (err_i),
    .clear_i    (clear_i),
    .log_o      (log_o),
    .log_src_o  (log_src_o),
    .irq_o      (irq_o),
    .drop_cnt_o (drop_cnt_o)
  );

  function automatic racl_error_log_t mk(input logic [31:0] a, input logic [3:0] r,
                                         input logic [7:0] u, input logic rd);
    racl_error_log_t e;
    e = '0;
    e.valid = 1'b1;
    e.racl_role = r;
    e.ctn_uid = u;
    e.read_access = rd;
    e.request_address = a;
    return e;
  endfunction

  function automatic racl_error_log_t with_ovf(input racl_error_log_t e);
    racl_error_log_t o;
    o = e;
    o.overflow = 1'b1;
    return o;
  endfunction

  function automatic logic [7:0] exp_cnt(input int n);
    return CntEn ? 8'(n) : 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; clear_i = 1'b0; err_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (log_o !== '0) begin $display("FAIL reset_log: got %h expected 0", log_o); fails++; end checks++;
    if (log_src_o !== 2'd0) begin $display("FAIL reset_src: got %0d expected 0", log_src_o); fails++; end checks++;
    if (irq_o !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", irq_o); fails++; end checks++;
    if (drop_cnt_o !== 8'd0) begin $display("FAIL reset_cnt: got %0d expected 0", drop_cnt_o); fails++; end checks++;
    $display("[%0t] reset: log=%h irq=%b cnt=%0d", $time, log_o, irq_o, drop_cnt_o);
  endtask

  task automatic test_single();
    racl_error_log_t r;
    r = mk(32'h4000_1000, 4'd3, 8'h00, 1'b1);
    err_i[2] = r;
    tick();
    err_i = '0;
    if (irq_o !== 1'b0) begin $display("FAIL single_early_irq: got %b expected 0", irq_o); fails++; end checks++;
    tick();
    if (log_o !== r) begin $display("FAIL single_log: got %h expected %h", log_o, r); fails++; end checks++;
    if (log_src_o !== 2'd2) begin $display("FAIL single_src: got %0d expected 2", log_src_o); fails++; end checks++;
    if (irq_o !== 1'b1) begin $display("FAIL single_irq: got %b expected 1", irq_o); fails++; end checks++;
    if (drop_cnt_o !== 8'd0) begin $display("FAIL single_cnt: got %0d expected 0", drop_cnt_o); fails++; end checks++;
    $display("[%0t] single: log=%h src=%0d", $time, log_o, log_src_o);
  endtask

  task automatic test_same_cycle();
    racl_error_log_t r0, r1, r3;
    do_reset();
    r0 = mk(32'h0000_0100, 4'd1, 8'h11, 1'b0);
    r1 = mk(32'h0000_0200, 4'd2, 8'h22, 1'b1);
    r3 = mk(32'h0000_0300, 4'd5, 8'h33, 1'b0);
    err_i[0] = r0; err_i[1] = r1; err_i[3] = r3;
    tick();
    err_i = '0;
    tick(); tick(); tick();
    if (log_o !== with_ovf(r0)) begin $display("FAIL same_log: got %h expected %h", log_o, with_ovf(r0)); fails++; end checks++;
    if (log_src_o !== 2'd0) begin $display("FAIL same_src: got %0d expected 0", log_src_o); fails++; end checks++;
    if (drop_cnt_o !== exp_cnt(2)) begin $display("FAIL same_cnt: got %0d expected %0d", drop_cnt_o, exp_cnt(2)); fails++; end checks++;
    $display("[%0t] same_cycle: log=%h src=%0d cnt=%0d", $time, log_o, log_src_o, drop_cnt_o);
  endtask

  task automatic test_back_to_back();
    racl_error_log_t rf, b1, b2;
    rf = mk(32'h1234_5678, 4'd7, 8'h44, 1'b1);
    b1 = mk(32'h0000_1111, 4'd8, 8'h55, 1'b0);
    b2 = mk(32'h0000_2222, 4'd9, 8'h66, 1'b1);
    do_clear();
    err_i[0] = rf;
    tick();
    err_i = '0;
    tick();
    if (log_o !== rf) begin $display("FAIL b2b_fill: got %h expected %h", log_o, rf); fails++; end checks++;
    err_i[1] = b1;
    tick();
    err_i[1] = b2;
    tick();
    err_i = '0;
    tick(); tick();
    if (log_o !== with_ovf(rf)) begin $display("FAIL b2b_log: got %h expected %h", log_o, with_ovf(rf)); fails++; end checks++;
    if (log_src_o !== 2'd0) begin $display("FAIL b2b_src: got %0d expected 0", log_src_o); fails++; end checks++;
    if (drop_cnt_o !== exp_cnt(2)) begin $display("FAIL b2b_cnt: got %0d expected %0d", drop_cnt_o, exp_cnt(2)); fails++; end checks++;
    $display("[%0t] back_to_back: log=%h cnt=%0d", $time, log_o, drop_cnt_o);
  endtask

  task automatic test_clear_pending();
    racl_error_log_t rf, c3;
    rf = mk(32'hAAAA_0000, 4'd2, 8'h77, 1'b0);
    c3 = mk(32'h3333_0003, 4'd4, 8'h88, 1'b1);
    do_clear();
    err_i[0] = rf;
    tick();
    err_i = '0;
    tick();
    err_i[3] = c3;
    tick();
    err_i = '0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    if (log_o !== '0) begin $display("FAIL clr_log: got %h expected 0", log_o); fails++; end checks++;
    if (irq_o !== 1'b0) begin $display("FAIL clr_irq: got %b expected 0", irq_o); fails++; end checks++;
    tick();
    if (log_o !== c3) begin $display("FAIL clr_slot_log: got %h expected %h", log_o, c3); fails++; end checks++;
    if (log_src_o !== 2'd3) begin $display("FAIL clr_slot_src: got %0d expected 3", log_src_o); fails++; end checks++;
    if (drop_cnt_o !== 8'd0) begin $display("FAIL clr_cnt: got %0d expected 0", drop_cnt_o); fails++; end checks++;
    $display("[%0t] clear_pending: log=%h src=%0d", $time, log_o, log_src_o);
  endtask

  task automatic test_pend_ovf();
    racl_error_log_t p0, p2a, p2b;
    p0  = mk(32'h0000_00A0, 4'd1, 8'h01, 1'b0);
    p2a = mk(32'h0000_00B0, 4'd2, 8'h02, 1'b1);
    p2b = mk(32'h0000_00C0, 4'd3, 8'h03, 1'b0);
    do_reset();
    err_i[0] = p0; err_i[2] = p2a;
    tick();
    err_i[0] = '0; err_i[2] = p2b;
    tick();
    err_i = '0;
    if (log_o !== p0) begin $display("FAIL povf_first: got %h expected %h", log_o, p0); fails++; end checks++;
    if (drop_cnt_o !== exp_cnt(1)) begin $display("FAIL povf_cnt: got %0d expected %0d", drop_cnt_o, exp_cnt(1)); fails++; end checks++;
    do_clear();
    if (drop_cnt_o !== 8'd0) begin $display("FAIL povf_clr_cnt: got %0d expected 0", drop_cnt_o); fails++; end checks++;
    tick();
    if (log_o !== with_ovf(p2a)) begin $display("FAIL povf_log: got %h expected %h", log_o, with_ovf(p2a)); fails++; end checks++;
    if (log_src_o !== 2'd2) begin $display("FAIL povf_src: got %0d expected 2", log_src_o); fails++; end checks++;
    $display("[%0t] pend_ovf: log=%h src=%0d", $time, log_o, log_src_o);
  endtask

  task automatic test_saturation();
    racl_error_log_t rf;
    rf = mk(32'h5555_0000, 4'd6, 8'h99, 1'b1);
    do_clear();
    err_i[0] = rf;
    tick();
    err_i = '0;
    tick();
    for (int i = 0; i < 300; i++) begin
      err_i[0] = mk(32'h1000_0000 + 32'(i), 4'd0, 8'(i), 1'b0);
      tick();
      if (i == 9) begin
        if (drop_cnt_o !== exp_cnt(9)) begin $display("FAIL sat_mid: got %0d expected %0d", drop_cnt_o, exp_cnt(9)); fails++; end checks++;
      end
      if (i == 255 || i == 256) begin
        if (drop_cnt_o !== exp_cnt(255)) begin $display("FAIL sat_edge%0d: got %0d expected %0d", i, drop_cnt_o, exp_cnt(255)); fails++; end checks++;
      end
    end
    err_i = '0;
    tick(); tick();
    if (drop_cnt_o !== exp_cnt(255)) begin $display("FAIL sat_cnt: got %0d expected %0d", drop_cnt_o, exp_cnt(255)); fails++; end checks++;
    if (log_o !== with_ovf(rf)) begin $display("FAIL sat_log: got %h expected %h", log_o, with_ovf(rf)); fails++; end checks++;
    $display("[%0t] saturation: cnt=%0d log=%h", $time, drop_cnt_o, log_o);
  endtask

  task automatic test_reset_mid();
    racl_error_log_t n0, n2;
    n0 = mk(32'hCAFE_0000, 4'd10, 8'hA0, 1'b1);
    n2 = mk(32'hCAFE_0002, 4'd12, 8'hA2, 1'b0);
    for (int k = 0; k < NumReq; k++) err_i[k] = mk(32'hDEAD_0000 + 32'(k), 4'(k), 8'(k), 1'b1);
    tick();
    err_i = '0;
    err_i[2] = mk(32'hDEAD_BEEF, 4'd15, 8'hFF, 1'b1);
    tick();
    err_i = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    if (log_o !== '0) begin $display("FAIL rmid_log: got %h expected 0", log_o); fails++; end checks++;
    if (log_src_o !== 2'd0) begin $display("FAIL rmid_src: got %0d expected 0", log_src_o); fails++; end checks++;
    if (irq_o !== 1'b0) begin $display("FAIL rmid_irq: got %b expected 0", irq_o); fails++; end checks++;
    if (drop_cnt_o !== 8'd0) begin $display("FAIL rmid_cnt: got %0d expected 0", drop_cnt_o); fails++; end checks++;
    err_i[0] = n0; err_i[2] = n2;
    tick();
    err_i = '0;
    tick();
    if (log_o !== n0) begin $display("FAIL rmid_fresh: got %h expected %h", log_o, n0); fails++; end checks++;
    if (log_src_o !== 2'd0) begin $display("FAIL rmid_fresh_src: got %0d expected 0", log_src_o); fails++; end checks++;
    tick();
    if (log_o !== with_ovf(n0)) begin $display("FAIL rmid_second: got %h expected %h", log_o, with_ovf(n0)); fails++; end checks++;
    if (drop_cnt_o !== exp_cnt(1)) begin $display("FAIL rmid_second_cnt: got %0d expected %0d", drop_cnt_o, exp_cnt(1)); fails++; end checks++;
    $display("[%0t] reset_mid: log=%h src=%0d cnt=%0d", $time, log_o, log_src_o, drop_cnt_o);
  endtask

  initial begin
    rst_i = 1'b1;
    clear_i = 1'b0;
    err_i = '0;
    test_reset();
    test_single();
    test_same_cycle();
    test_back_to_back();
    test_clear_pending();
    test_pend_ovf();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
